// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, flush, bubble-safe ctrl mask,
// optional 2-entry skid buffer (registered in_ready) and a saturating stall counter.
module pipe_stage_reg #(
  parameter int unsigned CTRL_W  = 8,
  parameter int unsigned DATA_W  = 96,
  parameter int unsigned SKID_EN = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              m_valid_q, m_valid_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              s_valid_q, s_valid_d;
  logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic [1:0]        occupancy_q, occupancy_d;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic              in_fire, out_fire;

  generate
    if (SKID_EN != 0) begin : g_skid
      assign in_ready = !s_valid_q;
    end else begin : g_noskid
      assign in_ready = out_ready | !m_valid_q;
    end
  endgenerate

  assign in_fire  = in_valid & in_ready;
  assign out_fire = m_valid_q & out_ready;

  always_comb begin
    m_valid_d = m_valid_q;
    m_ctrl_d  = m_ctrl_q;
    m_data_d  = m_data_q;
    s_valid_d = s_valid_q;
    s_ctrl_d  = s_ctrl_q;
    s_data_d  = s_data_q;
    if (flush) begin
      // Flush wins over any same-cycle accept; storage contents are left stale.
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (!m_valid_q) begin
      if (in_fire) begin
        m_valid_d = 1'b1;
        m_ctrl_d  = in_ctrl;
        m_data_d  = in_data;
      end
    end else if (out_fire) begin
      if (s_valid_q) begin
        m_ctrl_d  = s_ctrl_q;
        m_data_d  = s_data_q;
        s_valid_d = 1'b0;
      end else if (in_fire) begin
        m_ctrl_d = in_ctrl;
        m_data_d = in_data;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (in_fire && (SKID_EN != 0)) begin
      s_valid_d = 1'b1;
      s_ctrl_d  = in_ctrl;
      s_data_d  = in_data;
    end
    occupancy_d = {1'b0, m_valid_d} + {1'b0, s_valid_d};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid_q   <= 1'b0;
      m_ctrl_q    <= '0;
      m_data_q    <= '0;
      s_valid_q   <= 1'b0;
      s_ctrl_q    <= '0;
      s_data_q    <= '0;
      occupancy_q <= 2'd0;
    end else begin
      m_valid_q   <= m_valid_d;
      m_ctrl_q    <= m_ctrl_d;
      m_data_q    <= m_data_d;
      s_valid_q   <= s_valid_d;
      s_ctrl_q    <= s_ctrl_d;
      s_data_q    <= s_data_d;
      occupancy_q <= occupancy_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else if (m_valid_q && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign out_valid = m_valid_q;
  assign out_ctrl  = m_ctrl_q & {CTRL_W{m_valid_q}};
  assign out_data  = m_data_q;
  assign occupancy = occupancy_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed self-checking bench for pipe_stage_reg: skid, no-skid and narrow-counter instances.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic [7:0]  in_ctrl;
  logic [95:0] in_data;

  logic        a_in_ready, a_out_valid;
  logic [7:0]  a_out_ctrl;
  logic [95:0] a_out_data;
  logic [1:0]  a_occ;
  logic [15:0] a_cnt;

  logic        b_in_ready, b_out_valid;
  logic [7:0]  b_out_ctrl;
  logic [95:0] b_out_data;
  logic [1:0]  b_occ;
  logic [15:0] b_cnt;

  logic        c_in_ready, c_out_valid;
  logic [7:0]  c_out_ctrl;
  logic [95:0] c_out_data;
  logic [1:0]  c_occ;
  logic [3:0]  c_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  assign in_data = {64'h0, 24'h5A5A5A, in_ctrl};

  pipe_stage_reg u_skid (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_ctrl(a_out_ctrl), .out_data(a_out_data), .occupancy(a_occ), .stall_cnt(a_cnt)
  );

  pipe_stage_reg #(.SKID_EN(0)) u_noskid (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_ctrl(b_out_ctrl), .out_data(b_out_data), .occupancy(b_occ), .stall_cnt(b_cnt)
  );

  pipe_stage_reg #(.CNT_W(4)) u_cnt4 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(c_out_valid), .out_ready(out_ready),
    .out_ctrl(c_out_ctrl), .out_data(c_out_data), .occupancy(c_occ), .stall_cnt(c_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_ctrl = 8'h00;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_in_ready", 32'(a_in_ready), 32'd1);
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_out_ctrl", 32'(a_out_ctrl), 32'h0);
    chk("rst_occ", 32'(a_occ), 32'd0);
    chk("rst_cnt", 32'(a_cnt), 32'd0);

    // Streaming with out_ready high.
    out_ready = 1'b1; in_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      in_ctrl = 8'(i);
      tick();
      chk("stream_ctrl", 32'(a_out_ctrl), 32'(i));
      chk("stream_in_ready", 32'(a_in_ready), 32'd1);
      chk("stream_occ", 32'(a_occ), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("drain_valid", 32'(a_out_valid), 32'd0);
    chk("drain_occ", 32'(a_occ), 32'd0);
    chk("drain_cnt", 32'(a_cnt), 32'd0);

    // Backpressure into the skid entry.
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'h11;
    tick();
    chk("bp_a_occ", 32'(a_occ), 32'd1);
    in_ctrl = 8'h22;
    tick();
    chk("bp_occ2", 32'(a_occ), 32'd2);
    chk("bp_in_ready", 32'(a_in_ready), 32'd0);
    chk("bp_ctrl_a", 32'(a_out_ctrl), 32'h11);
    chk("bp_cnt1", 32'(a_cnt), 32'd1);
    in_valid = 1'b0;
    tick();
    chk("bp_hold_ctrl", 32'(a_out_ctrl), 32'h11);
    chk("bp_hold_data", a_out_data[31:0], 32'h5A5A5A11);
    chk("bp_cnt2", 32'(a_cnt), 32'd2);
    out_ready = 1'b1;
    tick();
    chk("bp_ctrl_b", 32'(a_out_ctrl), 32'h22);
    chk("bp_in_ready_back", 32'(a_in_ready), 32'd1);
    chk("bp_occ_b", 32'(a_occ), 32'd1);
    tick();
    chk("bp_empty", 32'(a_out_valid), 32'd0);
    chk("bp_cnt_final", 32'(a_cnt), 32'd2);

    // Flush at occupancy 2 with input presented.
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'h33;
    tick();
    in_ctrl = 8'h44;
    tick();
    chk("fl_occ2", 32'(a_occ), 32'd2);
    flush = 1'b1; in_ctrl = 8'h55;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_valid", 32'(a_out_valid), 32'd0);
    chk("fl_ctrl", 32'(a_out_ctrl), 32'h0);
    chk("fl_occ", 32'(a_occ), 32'd0);
    chk("fl_cnt_kept", 32'(a_cnt), 32'd4);
    out_ready = 1'b1;
    tick();
    chk("fl_no_ghost", 32'(a_out_valid), 32'd0);

    // Flush discards a real same-cycle input transfer.
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'h66;
    tick();
    flush = 1'b1; in_ctrl = 8'h77;
    #1;
    chk("fl_in_ready_ungated", 32'(a_in_ready), 32'd1);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl2_valid", 32'(a_out_valid), 32'd0);
    chk("fl2_occ", 32'(a_occ), 32'd0);
    out_ready = 1'b1;
    tick();
    chk("fl2_no_ghost", 32'(a_out_valid), 32'd0);
    chk("fl2_cnt", 32'(a_cnt), 32'd5);

    // Reset mid-stream at occupancy 2.
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'h88;
    tick();
    in_ctrl = 8'h99;
    tick();
    chk("mr_occ2", 32'(a_occ), 32'd2);
    #2 reset = 1'b1;
    #1;
    chk("mr_valid", 32'(a_out_valid), 32'd0);
    chk("mr_ctrl", 32'(a_out_ctrl), 32'h0);
    chk("mr_data", a_out_data[31:0], 32'h0);
    chk("mr_occ", 32'(a_occ), 32'd0);
    chk("mr_cnt", 32'(a_cnt), 32'd0);
    in_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    chk("mr_in_ready", 32'(a_in_ready), 32'd1);

    // No-skid instance: combinational ready.
    in_valid = 1'b1; in_ctrl = 8'hA1; out_ready = 1'b0;
    #1;
    chk("ns_ready_empty", 32'(b_in_ready), 32'd1);
    tick();
    chk("ns_ctrl_a", 32'(b_out_ctrl), 32'hA1);
    chk("ns_ready_full", 32'(b_in_ready), 32'd0);
    chk("ns_occ", 32'(b_occ), 32'd1);
    in_ctrl = 8'hA2; out_ready = 1'b1;
    #1;
    chk("ns_ready_comb", 32'(b_in_ready), 32'd1);
    tick();
    chk("ns_ctrl_b2b", 32'(b_out_ctrl), 32'hA2);
    chk("ns_occ_b2b", 32'(b_occ), 32'd1);
    in_valid = 1'b0;
    tick();
    chk("ns_empty", 32'(b_out_valid), 32'd0);
    chk("ns_occ_empty", 32'(b_occ), 32'd0);

    // Counter saturation on the 4-bit instance.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    in_valid = 1'b1; in_ctrl = 8'hC1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 14) chk("sat_cnt14", 32'(c_cnt), 32'd14);
      if (i == 15) chk("sat_cnt15", 32'(c_cnt), 32'd15);
    end
    chk("sat_cnt20", 32'(c_cnt), 32'd15);
    chk("sat_hold_ctrl", 32'(c_out_ctrl), 32'hC1);
    chk("wide_cnt20", 32'(a_cnt), 32'd20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register for the processor datapath. Successor to the fixed-field stage registers (IF/ID … MEM/WB).
- Carries a generic control bundle and a generic data bundle between stages using a valid/ready handshake.
- Adds stall (backpressure), flush, a bubble-safe control mask and an optional 2-entry skid buffer, so ready does not combinationally chain through the pipe.
- Exposes a saturating stall counter for performance debug.

Parameters:
- CTRL_W, 8, width of control bundle (RegWrite, MemtoReg, Rw, …); forced to 0 on output whenever out_valid=0.
- DATA_W, 96, width of data bundle (ReadData, ALUOut, PC, …); not masked.
- SKID_EN, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational ready.
- CNT_W, 16, width of the saturating stall counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- flush  in  1  synchronous squash of all held entries and of any same-cycle input transfer.
- in_valid  in  1  upstream stage presents an entry.
- in_ready  out  1  this stage accepts the entry this cycle.
- in_ctrl  in  CTRL_W  upstream control bundle.
- in_data  in  DATA_W  upstream data bundle.
- out_valid  out  1  held entry available to downstream.
- out_ready  in  1  downstream accepts this cycle.
- out_ctrl  out  CTRL_W  control bundle, AND-masked with out_valid.
- out_data  out  DATA_W  data bundle of the head entry.
- occupancy  out  2  entries held (0..2; max 1 when SKID_EN=0).
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

Behaviour:
- Reset (async, immediate):
  - Both entry valid bits = 0; all ctrl and data storage = 0.
  - out_valid=0, out_ctrl=0, out_data=0, occupancy=0, stall_cnt=0.
  - in_ready=1 after reset (SKID_EN=1).
  - Reset mid-transfer discards everything; there is no partial-state recovery.
- Transfer rules:
  - Input transfer: in_valid & in_ready at a rising edge.
  - Output transfer: out_valid & out_ready at a rising edge.
- Latency: an accepted entry appears on out_* on the next cycle (1-cycle latency); no combinational in→out path.
- SKID_EN=1 (storage = main reg M + skid reg S; out_* driven from M):
  - in_ready = !S.valid, from a register only.
  - Empty: accepted input goes to M.
  - M full, output transfer, input transfer: new entry goes to M.
  - M full, no output transfer, input transfer: new entry goes to S; in_ready drops next cycle.
  - M and S full, output transfer: S moves to M, S cleared, in_ready=1 next cycle.
  - Entry order is strictly FIFO; no entry is duplicated or lost under any out_ready pattern.
- SKID_EN=0:
  - in_ready = out_ready | !M.valid (combinational).
  - Accepted input loads M; M is cleared on an output transfer with no input transfer.
- Stall: while out_ready=0, out_valid/out_ctrl/out_data hold stable. A held entry never changes until it is transferred.
- Flush (synchronous):
  - On the edge with flush=1, both valid bits clear and occupancy=0 next cycle.
  - A same-cycle input transfer is discarded; flush has priority over accept.
  - in_ready is not gated by flush.
  - Data storage need not be cleared, but out_ctrl reads 0 through the mask.
- Bubble: out_valid=0 ⇒ out_ctrl = 0, so RegWrite/MemWrite-type bits are inert; out_data is don't-care.
- occupancy = M.valid + S.valid, registered.
- stall_cnt:
  - Increments on every edge with out_valid & !out_ready; saturates at 2^CNT_W−1.
  - Not cleared by flush; cleared only by reset.

Test Plan:
1. Reset asserted mid-stream with occupancy=2 → same cycle: out_valid=0, out_ctrl=0, occupancy=0, stall_cnt=0; after release in_ready=1.
2. Streaming (SKID_EN=1), out_ready=1, in_ctrl=0x01..0x05 on consecutive cycles → out_ctrl=0x01..0x05 each one cycle later; in_ready stays 1; occupancy=1.
3. Backpressure: entries A=0x11, B=0x22, out_ready=0 → occupancy=2, in_ready=0, out_ctrl=0x11 held. out_ready=1 for 2 cycles → outputs 0x11 then 0x22, in_ready back to 1, stall_cnt equals the stall cycle count.
4. Flush with occupancy=2 and in_valid=1 in the same cycle → next cycle out_valid=0, out_ctrl=0, occupancy=0; the flushed input never appears at the output.
5. SKID_EN=0, out_ready=0 with M full → in_ready=0 combinationally; raising out_ready in the same cycle → in_ready=1 and a back-to-back transfer completes.
6. CNT_W=4, stall held 20 cycles → stall_cnt saturates at 15 and stays there.
